// File: rtl/demux5_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-5 demultiplexer.
package demux5_reg_pkg;

    localparam int unsigned NLANES        = 5;
    localparam int unsigned SEL_W         = 3;
    localparam int unsigned SEL_MAX_LEGAL = 4;
    localparam int unsigned DROP_W        = 8;

    typedef logic [NLANES-1:0] lane_mask_t;
    typedef logic [SEL_W-1:0]  lane_sel_t;

    function automatic logic sel_is_legal(input lane_sel_t sel);
        return sel <= lane_sel_t'(SEL_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/demux5_reg_lane_buf.sv
// One-entry lane buffer: loads on request, empties when drained without refill.
module lane_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    // load is only granted when the slot is empty or being drained this cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux5_reg.sv
// Registered 1-to-5 demultiplexer with per-lane single-entry buffers and a
// saturating counter of words dropped for illegal lane selects.
module demux5_reg
    import demux5_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [NLANES-1:0]      out_valid,
    input  logic [NLANES-1:0]      out_ready,
    output logic [WIDTH-1:0]       y0,
    output logic [WIDTH-1:0]       y1,
    output logic [WIDTH-1:0]       y2,
    output logic [WIDTH-1:0]       y3,
    output logic [WIDTH-1:0]       y4,
    output logic [DROP_W-1:0]      drop_count
);

    lane_mask_t       sel_hit;
    lane_mask_t       lane_load;
    logic             accept;
    logic             drop;
    logic [WIDTH-1:0] lane_data [NLANES];

    // Illegal selects match no lane and leave in_ready at 1, so they drain.
    always_comb begin
        sel_hit  = '0;
        in_ready = 1'b1;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (in_sel == lane_sel_t'(k)) begin
                sel_hit[k] = 1'b1;
                in_ready   = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign accept    = in_valid && in_ready;
    assign lane_load = {NLANES{accept}} & sel_hit;
    assign drop      = accept && !sel_is_legal(in_sel);

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        lane_buf #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (lane_load[k]),
            .din     (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .dout    (lane_data[k])
        );
    end

    assign y0 = lane_data[0];
    assign y1 = lane_data[1];
    assign y2 = lane_data[2];
    assign y3 = lane_data[3];
    assign y4 = lane_data[4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_demux5_reg.sv
// Scoreboard bench for demux5_reg: per-lane expected-word queues fed by the
// driver, popped and compared by an independent monitor on every lane drain.
module tb_demux5_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic [4:0] out_valid;
    logic [4:0] out_ready;
    logic [7:0] y0, y1, y2, y3, y4;
    logic [7:0] drop_count;
    logic [7:0] y_arr [5];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] q [5][$];
    int unsigned exp_drop = 0;

    always #5 clk = ~clk;

    demux5_reg #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y4         (y4),
        .drop_count (drop_count)
    );

    assign y_arr[0] = y0;
    assign y_arr[1] = y1;
    assign y_arr[2] = y2;
    assign y_arr[3] = y3;
    assign y_arr[4] = y4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: lane occupancy and contents against the model queues.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(q[k].size() != 0));
                if (out_valid[k] && q[k].size() != 0) begin
                    chk($sformatf("y%0d", k), 32'(y_arr[k]), 32'(q[k][0]));
                    if (out_ready[k]) void'(q[k].pop_front());
                end
            end
            chk("drop_count", 32'(drop_count), exp_drop);
        end
    end

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic step(input bit v, input logic [2:0] s, input logic [7:0] d,
                        input logic [4:0] rdy, output bit acc);
        bit exp_rdy;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        exp_rdy = (s > 3'd4) ? 1'b1 : (q[s].size() == 0 || rdy[s]);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && in_ready;
        @(posedge clk);
        if (acc) begin
            if (s <= 3'd4) q[s].push_back(d);
            else if (exp_drop < 255) exp_drop++;
        end
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_y0"}, 32'(y0), 32'h0);
        chk({tag, "_y1"}, 32'(y1), 32'h0);
        chk({tag, "_y2"}, 32'(y2), 32'h0);
        chk({tag, "_y3"}, 32'(y3), 32'h0);
        chk({tag, "_y4"}, 32'(y4), 32'h0);
        chk({tag, "_drop_count"}, 32'(drop_count), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit have;
        logic [2:0] ps;
        logic [7:0] pd;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        #3;
        reset_checks("por");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Single route with backpressure on lane 2
        step(1, 3'd2, 8'hA5, 5'b00000, acc);
        chk("route_acc", 32'(acc), 32'h1);
        chk("route_out_valid", 32'(out_valid), 32'b00100);
        chk("route_y2", 32'(y2), 32'hA5);
        step(1, 3'd2, 8'h5A, 5'b00000, acc);
        chk("route_blocked", 32'(acc), 32'h0);
        chk("route_y2_hold", 32'(y2), 32'hA5);
        step(0, 3'd0, 8'h00, 5'b00100, acc);

        // Streaming into a continuously drained lane
        for (int i = 0; i < 16; i++) begin
            step(1, 3'd4, 8'(i), 5'b10000, acc);
            chk("stream_acc", 32'(acc), 32'h1);
        end
        step(0, 3'd0, 8'h00, 5'b10000, acc);

        // Backpressure isolation
        step(1, 3'd0, 8'h33, 5'b00000, acc);
        step(1, 3'd1, 8'h44, 5'b00000, acc);
        chk("iso_acc", 32'(acc), 32'h1);
        chk("iso_y0", 32'(y0), 32'h33);
        step(0, 3'd0, 8'h00, 5'b00011, acc);

        // Illegal selects saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            step(1, 3'(5 + i % 3), 8'(i), 5'b00000, acc);
            chk("illegal_acc", 32'(acc), 32'h1);
        end
        chk("drop_sat", 32'(drop_count), 32'd255);

        // Same-cycle drain and refill
        step(1, 3'd3, 8'h11, 5'b00000, acc);
        step(1, 3'd3, 8'h22, 5'b01000, acc);
        chk("refill_acc", 32'(acc), 32'h1);
        chk("refill_valid", 32'(out_valid[3]), 32'h1);
        chk("refill_y3", 32'(y3), 32'h22);
        step(0, 3'd0, 8'h00, 5'b01000, acc);

        // Asynchronous reset with lanes 1 and 3 full
        step(1, 3'd1, 8'hC1, 5'b00000, acc);
        step(1, 3'd3, 8'hC3, 5'b00000, acc);
        #2 reset_n = 1'b0;
        #1 reset_checks("midrst");
        for (int k = 0; k < 5; k++) q[k].delete();
        exp_drop = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Randomized traffic with source holding each word until accepted
        have = 0; ps = '0; pd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!have && $urandom_range(0, 9) < 7) begin
                have = 1;
                ps   = 3'($urandom_range(0, 7));
                pd   = 8'($urandom);
            end
            step(have, ps, pd, 5'($urandom), acc);
            if (acc) have = 0;
        end
        step(0, 3'd0, 8'h00, 5'b11111, acc);
        step(0, 3'd0, 8'h00, 5'b11111, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
